// File: rtl/rx_timing_delay_pkg.sv
// Shared widths and enable-phase constants for the RX timing/delay block.
package rx_timing_pkg;

  localparam int SAM_W_DEF  = 18;
  localparam int DATA_W_DEF = 2;
  localparam int PHASE_W    = 4;

  localparam logic [1:0]         SAM_ENA_PHASE = 2'd3;
  localparam logic [PHASE_W-1:0] SYM_ENA_PHASE = 4'd15;

  typedef struct packed {
    logic sam;
    logic sym;
  } ena_t;

  function automatic ena_t phase_enables(input logic [PHASE_W-1:0] phase);
    ena_t e;
    e.sam = (phase[1:0] == SAM_ENA_PHASE);
    e.sym = (phase == SYM_ENA_PHASE);
    return e;
  endfunction

endpackage

// File: rtl/rx_timing_delay_if.sv
// Configuration, stream and timing-output bundle of rx_timing_delay.
interface rx_timing_delay_if import rx_timing_pkg::*; #(
  parameter int SAM_W  = SAM_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic [1:0]              sam_delay;
  logic [7:0]              sym_delay;
  logic signed [SAM_W-1:0] sam_in;
  logic [DATA_W-1:0]       data_in;
  logic [PHASE_W-1:0]      clk_phase;
  logic                    sam_clk_ena;
  logic                    sym_clk_ena;
  logic                    sam_clk;
  logic                    sym_clk;
  logic signed [SAM_W-1:0] sam_out;
  logic [DATA_W-1:0]       data_out;

  modport master (
    output sam_delay, sym_delay, sam_in, data_in,
    input  clk_phase, sam_clk_ena, sym_clk_ena, sam_clk, sym_clk, sam_out, data_out
  );

  modport slave (
    input  sam_delay, sym_delay, sam_in, data_in,
    output clk_phase, sam_clk_ena, sym_clk_ena, sam_clk, sym_clk, sam_out, data_out
  );

endinterface

// File: rtl/rx_timing_delay_sym_delay_line.sv
// Symbol delay line: circular buffer with wrapping write pointer, saturating
// fill counter and write-first read mux; the memory itself is never cleared.
module sym_delay_line import rx_timing_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 256,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic [PTR_W-1:0]  delay,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  fill_r;
  logic [PTR_W-1:0]  rd_addr_s;
  logic [DATA_W-1:0] rd_sel_s;
  logic [DATA_W-1:0] dout_r;

  // read address and write-first bypass for a zero delay
  always_comb begin
    rd_addr_s = wr_ptr_r - delay;
    if (delay == '0) begin
      rd_sel_s = din;
    end else begin
      rd_sel_s = mem_r[rd_addr_s];
    end
  end

  // storage array, written on each symbol enable outside reset
  always_ff @(posedge clk) begin
    if (ena && !reset) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // pointer, fill tracking and registered output
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      fill_r   <= '0;
      dout_r   <= '0;
    end else if (ena) begin
      wr_ptr_r <= wr_ptr_r + 1'b1;
      if (fill_r != '1) begin
        fill_r <= fill_r + 1'b1;
      end
      // fill_r counts earlier captures, so the delayed symbol exists once it reaches delay
      dout_r <= (fill_r >= delay) ? rd_sel_s : '0;
    end
  end

  assign dout = dout_r;

endmodule

// File: rtl/rx_timing_delay.sv
// RX timing generator with configurable sample and symbol delay paths.
// Define TIMING_CLK_OUT_EN to drive sam_clk/sym_clk; otherwise they are tied low.
module rx_timing_delay import rx_timing_pkg::*; #(
  parameter int SAM_W     = SAM_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SYM_DEPTH = 256
) (
  input logic             clk,
  input logic             reset,
  rx_timing_delay_if.slave bus
);

  localparam int SYM_PTR_W = $clog2(SYM_DEPTH);

  logic [PHASE_W-1:0]      phase_r;
  logic [PHASE_W-1:0]      phase_nxt_s;
  ena_t                    ena_nxt_s;
  logic                    sam_ena_r;
  logic                    sym_ena_r;
  logic signed [SAM_W-1:0] hist_r [3];
  logic [1:0]              sam_fill_r;
  logic signed [SAM_W-1:0] sam_sel_s;
  logic signed [SAM_W-1:0] sam_out_r;
  logic [DATA_W-1:0]       data_out_s;

  // next phase and the enables it implies, so the enables line up with clk_phase
  always_comb begin
    phase_nxt_s = phase_r + 4'd1;
    ena_nxt_s   = phase_enables(phase_nxt_s);
  end

  // phase counter and enable pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_r   <= '0;
      sam_ena_r <= 1'b0;
      sym_ena_r <= 1'b0;
    end else begin
      phase_r   <= phase_nxt_s;
      sam_ena_r <= ena_nxt_s.sam;
      sym_ena_r <= ena_nxt_s.sym;
    end
  end

  // newest sample plus three stored ones form the 4-deep history window
  always_comb begin
    case (bus.sam_delay)
      2'd0:    sam_sel_s = bus.sam_in;
      2'd1:    sam_sel_s = hist_r[0];
      2'd2:    sam_sel_s = hist_r[1];
      2'd3:    sam_sel_s = hist_r[2];
      default: sam_sel_s = bus.sam_in;
    endcase
  end

  // sample history, fill counter and delayed sample output
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_r[0]  <= '0;
      hist_r[1]  <= '0;
      hist_r[2]  <= '0;
      sam_fill_r <= 2'd0;
      sam_out_r  <= '0;
    end else if (sam_ena_r) begin
      hist_r[0] <= bus.sam_in;
      hist_r[1] <= hist_r[0];
      hist_r[2] <= hist_r[1];
      if (sam_fill_r != 2'd3) begin
        sam_fill_r <= sam_fill_r + 2'd1;
      end
      sam_out_r <= (sam_fill_r >= bus.sam_delay) ? sam_sel_s : '0;
    end
  end

  sym_delay_line #(
    .DATA_W (DATA_W),
    .DEPTH  (SYM_DEPTH),
    .PTR_W  (SYM_PTR_W)
  ) u_sym_delay_line (
    .clk   (clk),
    .reset (reset),
    .ena   (sym_ena_r),
    .delay (bus.sym_delay[SYM_PTR_W-1:0]),
    .din   (bus.data_in),
    .dout  (data_out_s)
  );

`ifdef TIMING_CLK_OUT_EN
  logic sam_clk_r;
  logic sym_clk_r;

  // divided clock outputs mirror phase bits 1 and 3
  always_ff @(posedge clk) begin
    if (reset) begin
      sam_clk_r <= 1'b0;
      sym_clk_r <= 1'b0;
    end else begin
      sam_clk_r <= phase_nxt_s[1];
      sym_clk_r <= phase_nxt_s[3];
    end
  end

  assign bus.sam_clk = sam_clk_r;
  assign bus.sym_clk = sym_clk_r;
`else
  assign bus.sam_clk = 1'b0;
  assign bus.sym_clk = 1'b0;
`endif

  assign bus.clk_phase   = phase_r;
  assign bus.sam_clk_ena = sam_ena_r;
  assign bus.sym_clk_ena = sym_ena_r;
  assign bus.sam_out     = sam_out_r;
  assign bus.data_out    = data_out_s;

endmodule

// File: tb/tb_rx_timing_delay.sv
// Randomised bench for rx_timing_delay against a queue-based reference model.
module tb_rx_timing_delay;
  import rx_timing_pkg::*;

  localparam int SAM_W  = 18;
  localparam int DATA_W = 2;

  logic clk = 1'b0;
  logic reset;

  rx_timing_delay_if #(.SAM_W(SAM_W), .DATA_W(DATA_W)) bus ();

  rx_timing_delay #(.SAM_W(SAM_W), .DATA_W(DATA_W), .SYM_DEPTH(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mode  = 0;
  int n_sam = 0;
  int n_sym = 0;
  bit sam_cap, sym_cap;
  logic signed [SAM_W-1:0] samq[$];
  logic [DATA_W-1:0]       symq[$];
  logic signed [SAM_W-1:0] exp_sam = '0;
  logic [DATA_W-1:0]       exp_dat = '0;
  logic signed [SAM_W-1:0] rec_sam [5];
  logic [DATA_W-1:0]       rec_dat [3];

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, compare outputs.
  task automatic step();
    int ph;
    int d;
    ph = cyc % 16;
    if (mode == 0) begin
      bus.sam_in  = SAM_W'(samq.size() + 1);
      bus.data_in = DATA_W'((symq.size() + 1) % 4);
    end else begin
      bus.sam_in  = SAM_W'($urandom);
      bus.data_in = DATA_W'($urandom);
    end
    sam_cap = !reset && (ph % 4 == 3);
    sym_cap = !reset && (ph == 15);
    @(posedge clk);
    if (reset) begin
      cyc = 0;
      samq.delete();
      symq.delete();
      exp_sam = '0;
      exp_dat = '0;
    end else begin
      cyc++;
      if (sam_cap) begin
        samq.push_back(bus.sam_in);
        d = int'(bus.sam_delay);
        exp_sam = (samq.size() > d) ? samq[samq.size() - 1 - d] : '0;
      end
      if (sym_cap) begin
        symq.push_back(bus.data_in);
        d = int'(bus.sym_delay);
        exp_dat = (symq.size() > d) ? symq[symq.size() - 1 - d] : '0;
      end
    end
    #1;
    ph = cyc % 16;
    check("clk_phase", bus.clk_phase, ph);
    check("sam_clk_ena", bus.sam_clk_ena, (ph % 4 == 3));
    check("sym_clk_ena", bus.sym_clk_ena, (ph == 15));
`ifdef TIMING_CLK_OUT_EN
    check("sam_clk", bus.sam_clk, (ph / 2) % 2);
    check("sym_clk", bus.sym_clk, ph / 8);
`else
    check("sam_clk", bus.sam_clk, 0);
    check("sym_clk", bus.sym_clk, 0);
`endif
    check("sam_out", bus.sam_out, exp_sam);
    check("data_out", bus.data_out, exp_dat);
    if (bus.sam_clk_ena) n_sam++;
    if (bus.sym_clk_ena) begin
      n_sym++;
      check("sym_with_sam", bus.sam_clk_ena, 1);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_phase"}, bus.clk_phase, 0);
    check({tag, "_sam_ena"}, bus.sam_clk_ena, 0);
    check({tag, "_sym_ena"}, bus.sym_clk_ena, 0);
    check({tag, "_sam_out"}, bus.sam_out, 0);
    check({tag, "_data_out"}, bus.data_out, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.sam_delay = 2'd0;
    bus.sym_delay = 8'd0;
    bus.sam_in    = '0;
    bus.data_in   = '0;
    mode = 0;

    // reset state and 64-clock enable pattern with a zero-delay ramp
    do_reset();
    check_reset_state("rst");
    n_sam = 0;
    n_sym = 0;
    repeat (64) step();
    check("sam_pulses_64", n_sam, 16);
    check("sym_pulses_64", n_sym, 4);
    check("ramp_d0_last", bus.sam_out, 16);
    check("sym_d0_last", bus.data_out, 0);

    // sample delay 3 and symbol delay 52 on ramps
    bus.sam_delay = 2'd3;
    bus.sym_delay = 8'd52;
    do_reset();
    while (samq.size() < 5) begin
      step();
      if (sam_cap) rec_sam[samq.size() - 1] = bus.sam_out;
    end
    check("ramp_d3_e1", rec_sam[0], 0);
    check("ramp_d3_e2", rec_sam[1], 0);
    check("ramp_d3_e3", rec_sam[2], 0);
    check("ramp_d3_e4", rec_sam[3], 1);
    check("ramp_d3_e5", rec_sam[4], 2);
    while (symq.size() < 54) begin
      step();
      if (sym_cap && symq.size() >= 52) rec_dat[symq.size() - 52] = bus.data_out;
    end
    check("sym52_e52", rec_dat[0], 0);
    check("sym52_e53", rec_dat[1], 1);
    check("sym52_e54", rec_dat[2], 2);

    // random data, max symbol delay across pointer wrap, then delay 1
    mode = 1;
    bus.sym_delay = 8'd255;
    do_reset();
    while (symq.size() < 310) begin
      if ($urandom_range(7) == 0) bus.sam_delay = 2'($urandom);
      step();
    end
    bus.sym_delay = 8'd1;
    while (symq.size() < 330) step();
    while (symq.size() < 380) begin
      if (cyc % 16 == 3) bus.sym_delay = 8'($urandom);
      if ($urandom_range(3) == 0) bus.sam_delay = 2'($urandom);
      step();
    end

    // reset landing on a symbol-enable clock, then the 52-delay ramp again
    mode = 0;
    bus.sam_delay = 2'd0;
    bus.sym_delay = 8'd52;
    repeat (16) if (cyc % 16 != 15) step();
    check("pre_reset_sym_ena", bus.sym_clk_ena, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_state("mid_rst");
    n_sam = 0;
    n_sym = 0;
    repeat (64) step();
    check("restart_sam_pulses", n_sam, 16);
    check("restart_sym_pulses", n_sym, 4);
    while (symq.size() < 53) step();
    check("restart_sym52_e53", bus.data_out, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_timing_delay.md
RX_TIMING_DELAY -- requirements
Module: rx_timing_delay

Interface
REQ-001 Parameter SAM_W, default 18, sets the width of the signed sample path.
REQ-002 Parameter DATA_W, default 2, sets the width of the symbol-data path.
REQ-003 Parameter SYM_DEPTH, default 256, sets the symbol delay-line depth (power of two, supports delays 0..SYM_DEPTH-1).
REQ-004 Ports: one clock; reset is synchronous and active-high (ports named clk and reset).
REQ-005 clk  in  1  system clock; all logic is on its rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 sam_delay  in  2  extra sample delay, 0..3 samples.
REQ-008 sym_delay  in  8  symbol delay, 0..255 symbols.
REQ-009 sam_in  in  SAM_W signed  upsampled sample stream, one value per sample enable.
REQ-010 data_in  in  DATA_W  transmitted symbol bits, one value per symbol enable.
REQ-011 clk_phase  out  4  free-running phase counter.
REQ-012 sam_clk_ena  out  1  one-clk sample-enable pulse.
REQ-013 sym_clk_ena  out  1  one-clk symbol-enable pulse.
REQ-014 sam_clk  out  1  divided-by-4 sample clock (logic signal, not used to clock anything).
REQ-015 sym_clk  out  1  divided-by-16 symbol clock (logic signal, not used to clock anything).
REQ-016 sam_out  out  SAM_W signed  sample stream after the configured sample delay.
REQ-017 data_out  out  DATA_W  symbol data after the configured symbol delay.

Function
REQ-018 clk_phase increments by 1 every clk and wraps from 15 to 0.
REQ-019 sam_clk_ena and sym_clk_ena are registered pulses derived from clk_phase.
- sam_clk_ena is high for exactly one clk when clk_phase[1:0]==3, giving a period of 4 clk.
- sym_clk_ena is high for exactly one clk when clk_phase==15, giving a period of 16 clk.
- On every clk where sym_clk_ena is high, sam_clk_ena is also high.
REQ-020 sam_clk equals clk_phase[1] and sym_clk equals clk_phase[3].
REQ-021 Sample path captures sam_in only on clks where sam_clk_ena is high, into a 4-entry history.
REQ-022 Sample output update:
- On the clk of the k-th sample capture, sam_out takes the sample captured at capture k-sam_delay.
- sam_delay=0 gives sam_out=sam_in, visible one clk after the enable.
REQ-023 Symbol path captures data_in only on clks where sym_clk_ena is high.
- Storage is a circular buffer of SYM_DEPTH entries with a write pointer that wraps.
REQ-024 Symbol output update:
- On the k-th symbol capture, data_out takes the value captured at capture k-sym_delay; read address = write pointer minus sym_delay, modulo SYM_DEPTH.
- The write and the read occur on the same clk.
- sym_delay=0 gives the value written on that same clk (write-first bypass).
REQ-025 Until at least sym_delay captures have occurred since reset, data_out is driven 0; tracked by a saturating fill counter, so the memory is not cleared.
REQ-026 Same rule for the sample path: until at least sam_delay captures have occurred since reset, sam_out is driven 0.
REQ-027 sam_out and data_out hold their value between enables.
REQ-028 A delay input change takes effect at the next corresponding enable, with no flush and no glitch in between.

Reset
REQ-029 On reset:
- clk_phase is set to 0, sam_clk_ena and sym_clk_ena to 0, sam_out to 0 and data_out to 0.
- Both fill counters are cleared, the write pointer is set to 0 and the sample history is cleared.
- The first sam_clk_ena occurs 3 clks after reset is released.
REQ-030 Reset asserted mid-operation overrides any enable on the same clk; operation restarts from phase 0.

Configuration
REQ-031 Macro TIMING_CLK_OUT_EN selects the clock outputs.
- When defined, sam_clk and sym_clk behave per REQ-020.
- When undefined, sam_clk and sym_clk are tied to constant 0 and their dividers are not synthesized.
- Enables and delay paths are identical either way.

Structure
REQ-032 Shared package rx_timing_pkg holds SAM_W and DATA_W defaults, the phase width, the sample-enable phase value 3 and the symbol-enable phase value 15.
REQ-033 The symbol circular buffer is one sub-module, sym_delay_line, containing the memory, write pointer, fill counter and read mux.
- The phase counter and the sample delay stay in the top level.

Verification
REQ-034 Release reset, run 64 clk -> clk_phase counts 0..15 repeatedly; exactly 16 sam_clk_ena pulses and 4 sym_clk_ena pulses, each one clk wide; every sym_clk_ena is coincident with a sam_clk_ena.
REQ-035 sam_delay=0, feed sam_in=1,2,3,... one per sample enable -> sam_out equals the current sample one clk after each enable.
REQ-036 sam_delay=3, same ramp -> sam_out reads 0,0,0,1,2,... on the 1st..5th enables.
REQ-037 sym_delay=52, data_in=enable index mod 4 -> data_out is 0 for the first 52 symbol enables, then equals (k-52) mod 4.
REQ-038 sym_delay=255 with more than 300 symbols, then sym_delay changed to 1 -> correct values across write-pointer wrap; the new delay is in effect at the next symbol enable.
REQ-039 Assert reset mid-stream on a sym_clk_ena clk -> all outputs become 0 on the next clk; the pattern restarts as in REQ-034 and REQ-037.
